// File: rtl/rrspsram_pkg.sv
// rrspsram_pkg: shared state encoding and configuration helpers for rrspsram_param
package rrspsram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

    function automatic int lanes(input int data_width, input int lane_width);
        return data_width / lane_width;
    endfunction

    function automatic bit cfg_ok(input int data_width, input int lane_width,
                                  input int depth, input int addr_width);
        return (data_width % lane_width == 0) && (depth >= 1) && (depth <= (1 << addr_width));
    endfunction

endpackage

// File: rtl/rrspsram_clr_seq.sv
// rrspsram_clr_seq: post-reset clear sequencer, walks every word once then opens the port
module rrspsram_clr_seq
    import rrspsram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 6,
    parameter int DEPTH          = 64,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  rdy_o,
    output logic                  clr_we_o,
    output logic [ADDR_WIDTH-1:0] clr_addr_o
);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
            cnt_q   <= '0;
        end else if (state_q == ST_INIT) begin
            cnt_q <= cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == ADDR_WIDTH'(DEPTH - 1))
                state_q <= ST_IDLE;
        end
    end

    assign rdy_o      = state_q == ST_IDLE;
    assign clr_we_o   = state_q == ST_INIT;
    assign clr_addr_o = cnt_q;

endmodule

// File: rtl/rrspsram_param.sv
// rrspsram_param: parametrised single-port SRAM, registered read, lane enables, post-reset clear.
// Define RRSPSRAM_OUTREG_EN to add a second output register stage (read latency 2).
module rrspsram_param
    import rrspsram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 6,
    parameter int DATA_WIDTH     = 16,
    parameter int LANE_WIDTH     = 8,
    parameter int DEPTH          = 64,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                             CLK,
    input  logic                             RST_N,
    input  logic                             EN,
    input  logic                             WE,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] BE,
    input  logic [ADDR_WIDTH-1:0]            A,
    input  logic [DATA_WIDTH-1:0]            DI,
    output logic                             RDY,
    output logic [DATA_WIDTH-1:0]            DO,
    output logic                             DO_VALID
);

    localparam int NL = lanes(DATA_WIDTH, LANE_WIDTH);

    if (!cfg_ok(DATA_WIDTH, LANE_WIDTH, DEPTH, ADDR_WIDTH)) begin : g_bad_cfg
        $error("rrspsram_param: DATA_WIDTH must be a multiple of LANE_WIDTH and 1 <= DEPTH <= 2**ADDR_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  in_rng;
    logic                  rd;
    logic [ADDR_WIDTH-1:0] wa;
    logic [DATA_WIDTH-1:0] wd;
    logic [NL-1:0]         wbe;
    logic [DATA_WIDTH-1:0] do_q, do_d;
    logic                  vld_q;

    rrspsram_clr_seq #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .DEPTH         (DEPTH),
        .CLEAR_ON_RESET(CLEAR_ON_RESET)
    ) u_clr_seq (
        .clk_i     (CLK),
        .rst_ni    (RST_N),
        .rdy_o     (RDY),
        .clr_we_o  (clr_we),
        .clr_addr_o(clr_addr)
    );

    if (DEPTH < 2**ADDR_WIDTH) begin : g_rng
        assign in_rng = A < ADDR_WIDTH'(DEPTH);
    end else begin : g_full
        assign in_rng = 1'b1;
    end

    // Clear writes own the port while RDY is low, so user writes never collide with them
    always_comb begin
        wa  = clr_we ? clr_addr : A;
        wd  = clr_we ? '0 : DI;
        wbe = clr_we ? '1 : ((EN && WE && RDY && in_rng) ? BE : '0);
        rd  = EN && !WE && RDY;
        do_d = rd ? (in_rng ? mem[A] : '0) : do_q;
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < NL; i++)
            if (wbe[i])
                mem[wa][i*LANE_WIDTH +: LANE_WIDTH] <= wd[i*LANE_WIDTH +: LANE_WIDTH];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            do_q  <= '0;
            vld_q <= 1'b0;
        end else begin
            do_q  <= do_d;
            vld_q <= rd;
        end
    end

`ifdef RRSPSRAM_OUTREG_EN
    logic [DATA_WIDTH-1:0] do2_q;
    logic                  vld2_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            do2_q  <= '0;
            vld2_q <= 1'b0;
        end else begin
            do2_q  <= do_q;
            vld2_q <= vld_q;
        end
    end

    assign DO       = do2_q;
    assign DO_VALID = vld2_q;
`else
    assign DO       = do_q;
    assign DO_VALID = vld_q;
`endif

endmodule

// File: doc/rrspsram_param.md
Name: rrspsram_param

Overview:
- Parametrised single-port synchronous SRAM with a registered read port, generalising the fixed 64x16 codec-buffer RAM.
- Adds per-lane write enables, a read-valid strobe and a post-reset clear sequencer, which zeroes the array and holds off requests until done.
- Used as the common storage primitive for MPEG4 line and macroblock buffers.

Parameters:
ADDR_WIDTH, 6, address bits
DATA_WIDTH, 16, word width; must be a multiple of LANE_WIDTH
LANE_WIDTH, 8, bits per write-enable lane
DEPTH, 64, words implemented; 1 <= DEPTH <= 2**ADDR_WIDTH
CLEAR_ON_RESET, 1, 1 = zero the array after reset; 0 = no clear, RDY high out of reset

Ports:
CLK  input  1  clock, all state on rising edge
RST_N  input  1  asynchronous active-low reset
EN  input  1  request strobe, sampled when RDY=1
WE  input  1  1 = write, 0 = read (qualified by EN)
BE  input  DATA_WIDTH/LANE_WIDTH  lane write enables; lane i covers DI[i*LANE_WIDTH +: LANE_WIDTH]
A  input  ADDR_WIDTH  word address
DI  input  DATA_WIDTH  write data
RDY  output  1  1 = requests accepted
DO  output  DATA_WIDTH  registered read data
DO_VALID  output  1  one-cycle strobe, DO holds fresh read data

Behaviour:
- Reset (RST_N=0, asynchronous):
  - DO=0, DO_VALID=0, clear counter=0.
  - State=INIT if CLEAR_ON_RESET, else IDLE.
  - RDY=0 in INIT, 1 in IDLE.
  - Array contents are not touched by reset itself.
- FSM, two states:
  - INIT: each cycle writes 0 to mem[counter], counter++. When counter==DEPTH-1, that word is written and the FSM goes to IDLE. RDY stays 0 for exactly DEPTH cycles after reset release.
  - IDLE: terminal state until the next reset.
- Requests while RDY=0 are ignored entirely: no write, no DO change, no DO_VALID.
- Reset asserted mid-INIT: the counter restarts at 0 and the full clear is repeated after release.
- Read (EN=1, WE=0, RDY=1) at edge N:
  - Edge N captures mem[A] into DO and sets DO_VALID=1.
  - Latency is 1 cycle; the data is visible during cycle N+1.
  - DO_VALID deasserts at the next edge unless another read is accepted there. Back-to-back reads give one word per cycle.
- DO holds its last value when there is no read. Writes never alter DO and never raise DO_VALID.
- Write (EN=1, WE=1, RDY=1):
  - Only lanes with BE[i]=1 are updated; BE=0 is a legal no-op write.
- Read-after-write to the same address on the next cycle returns the newly written data. No bypass is needed: write and read happen on different edges.
- Out-of-range address (A >= DEPTH, only possible when DEPTH < 2**ADDR_WIDTH):
  - Write is discarded.
  - Read returns DO=0 with DO_VALID=1.
- EN=0: the WE, BE, A and DI inputs are don't-care.

Optional Feature:
RRSPSRAM_OUTREG_EN
- Defined: adds a second output register stage. Read latency becomes 2 cycles and DO_VALID is delayed to match. Reads stay fully pipelined at one per cycle. Both stages reset to 0. A read accepted in the cycle before reset is lost.
- Undefined: single output register, latency 1 as above.

Decomposition:
- Package rrspsram_pkg:
  - State encoding: ST_INIT=1'b0, ST_IDLE=1'b1.
  - Function lanes(DATA_WIDTH, LANE_WIDTH).
  - Elaboration-time checks: DATA_WIDTH % LANE_WIDTH == 0; DEPTH <= 2**ADDR_WIDTH.
- One sub-module, rrspsram_clr_seq:
  - Contains the INIT/IDLE FSM and the clear counter.
  - Outputs RDY, clr_we and clr_addr.
  - The top level muxes clear writes ahead of user writes.

Test Plan:
- Clear sequence: release RST_N with defaults, EN=1 read A=5 every cycle -> RDY low for exactly 64 cycles, no DO_VALID. Then the first accepted read gives DO=16'h0000, DO_VALID=1 one cycle later.
- Byte-lane write: write A=3 DI=16'hABCD BE=2'b11, then DI=16'h1234 BE=2'b01, then read A=3 -> DO=16'hAB34.
- Back-to-back reads: after writing A=0..3 = 16'h0010..16'h0013, read A=0..3 on consecutive cycles -> DO = 0010, 0011, 0012, 0013 on consecutive cycles, DO_VALID high four cycles. DO then holds 0013 with DO_VALID=0.
- Reset mid-clear: assert RST_N=0 at INIT cycle 20, release -> RDY low a full 64 cycles again. DO=0 and DO_VALID=0 immediately on assertion.
- Out-of-range: DEPTH=48, ADDR_WIDTH=6. Write A=50 DI=16'hFFFF, read A=50 -> DO=0, DO_VALID=1. A read of A=47 is unaffected.
- With RRSPSRAM_OUTREG_EN: read A=3 holding 16'hAB34 -> DO=16'hAB34 and DO_VALID=1 exactly two cycles after the request.
